mem_bus_responder: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 67 ++++++
 rtl/mem_bus_responder_wait_state_calc.sv | 39 +++
 rtl/mem_bus_responder.sv | 175 +++++++++++++++++
 tb/tb_mem_bus_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory bus responder.
// Access sizes, GBA regions and wait-state tables.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  typedef enum logic [3:0] {
    RG_BIOS     = 4'd0,
    RG_UNMAPPED = 4'd1,
    RG_EWRAM    = 4'd2,
    RG_IWRAM    = 4'd3,
    RG_IO       = 4'd4,
    RG_PAL      = 4'd5,
    RG_VRAM     = 4'd6,
    RG_OAM      = 4'd7,
    RG_WS0      = 4'd8,
    RG_WS1      = 4'd9,
    RG_WS2      = 4'd10,
    RG_SRAM     = 4'd11
  } mem_region_t;

  // Non-sequential wait table {4,3,2,8}, entry i at bits [4i+3:4i].
  localparam logic [15:0] N_WAIT_TAB = {4'd8, 4'd2, 4'd3, 4'd4};

  function automatic logic [3:0] n_wait(input logic [1:0] sel);
    return N_WAIT_TAB[{sel, 2'b00} +: 4];
  endfunction

  function automatic mem_region_t region_of(input logic [3:0] nib);
    mem_region_t r;
    unique case (nib)
      4'h0: r = RG_BIOS;
      4'h1: r = RG_UNMAPPED;
      4'h2: r = RG_EWRAM;
      4'h3: r = RG_IWRAM;
      4'h4: r = RG_IO;
      4'h5: r = RG_PAL;
      4'h6: r = RG_VRAM;
      4'h7: r = RG_OAM;
      4'h8, 4'h9: r = RG_WS0;
      4'hA, 4'hB: r = RG_WS1;
      4'hC, 4'hD: r = RG_WS2;
      default: r = RG_SRAM;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] bytes_of(input access_size_t sz);
    logic [31:0] b;
    unique case (sz)
      SZ_BYTE: b = 32'd1;
      SZ_HALF: b = 32'd2;
      default: b = 32'd4;
    endcase
    return b;
  endfunction

  function automatic logic is_rom(input mem_region_t r);
    return (r == RG_WS0) || (r == RG_WS1) ||
           (r == RG_WS2) || (r == RG_SRAM);
  endfunction

endpackage

// File: rtl/mem_bus_responder_wait_state_calc.sv
// Wait-state lookup from region, N/S flag and WAITCNT.
// Purely combinational; W never exceeds 8.
module wait_state_calc
  import cpu_types_pkg::*;
#(
  parameter int EWRAM_WAIT = 2
) (
  input  mem_region_t region,
  input  logic        seq,
  input  logic [15:0] waitcnt,
  output logic [3:0]  w
);

  logic unused_waitcnt_hi;
  assign unused_waitcnt_hi = ^waitcnt[15:11];

  // Map region and access type to a wait count
  always_comb begin
    w = '0;
    unique case (region)
      RG_EWRAM: w = 4'(EWRAM_WAIT);
      RG_WS0: begin
        if (seq) w = waitcnt[4] ? 4'd1 : 4'd2;
        else     w = n_wait(waitcnt[3:2]);
      end
      RG_WS1: begin
        if (seq) w = waitcnt[7] ? 4'd1 : 4'd4;
        else     w = n_wait(waitcnt[6:5]);
      end
      RG_WS2: begin
        if (seq) w = waitcnt[10] ? 4'd1 : 4'd8;
        else     w = n_wait(waitcnt[9:8]);
      end
      RG_SRAM: w = n_wait(waitcnt[1:0]);
      default: w = '0;
    endcase
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder for core bus requests.
// Region decode, wait states, lane steering, read format.
module mem_bus_responder
  import cpu_types_pkg::*;
#(
  parameter int EWRAM_WAIT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  access_size_t req_size,
  input  logic [31:0]  req_wdata,
  input  logic [15:0]  waitcnt,
  output logic         busy,
  output logic         resp_valid,
  output logic [31:0]  resp_rdata,
  output logic         mem_en,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [3:0]   mem_be,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t       state;
  logic [3:0]   cnt;

  mem_region_t  req_region;
  logic         accept;
  logic         mapped;
  logic         seq;
  logic [3:0]   w;

  logic         last_valid;
  logic [31:0]  last_addr;
  mem_region_t  last_region;

  logic [1:0]   lat_lane;
  access_size_t lat_size;
  logic         lat_unmapped;
  logic         cap_now;
  logic [31:0]  hold;

  logic [31:0]  rd_src;
  logic [63:0]  rd_rot;

  assign req_region = region_of(req_addr[27:24]);
  assign mapped     = req_region != RG_UNMAPPED;
  assign accept     = (state == S_IDLE) && req_valid && !reset;

  assign seq = resp_valid && last_valid &&
               is_rom(req_region) &&
               (req_region == last_region) &&
               (req_addr == last_addr + bytes_of(req_size)) &&
               (req_addr[16:0] != 17'd0);

  wait_state_calc #(
    .EWRAM_WAIT(EWRAM_WAIT)
  ) u_wsc (
    .region (req_region),
    .seq    (seq),
    .waitcnt(waitcnt),
    .w      (w)
  );

  assign mem_en   = accept && mapped;
  assign mem_we   = mem_en && req_write;
  assign mem_addr = {req_addr[31:2], 2'b00};

  // Steer store data onto byte lanes
  always_comb begin
    mem_be    = 4'b1111;
    mem_wdata = req_wdata;
    unique case (req_size)
      SZ_BYTE: begin
        mem_be    = 4'b0001 << req_addr[1:0];
        mem_wdata = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        mem_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = req_wdata;
      end
    endcase
  end

  // Request FSM: accept, count wait states, pulse response
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      busy        <= 1'b0;
      resp_valid  <= 1'b0;
      last_valid  <= 1'b0;
      last_addr   <= '0;
      last_region <= RG_BIOS;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            last_valid  <= 1'b1;
            last_addr   <= req_addr;
            last_region <= req_region;
            if (w == 4'd0) begin
              resp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= w;
              busy  <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            resp_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Latch request attributes and capture read data
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_lane     <= '0;
      lat_size     <= SZ_BYTE;
      lat_unmapped <= 1'b0;
      cap_now      <= 1'b0;
      hold         <= '0;
    end else begin
      cap_now <= accept && mapped && !req_write;
      if (cap_now) hold <= mem_rdata;
      if (accept) begin
        lat_lane     <= req_addr[1:0];
        lat_size     <= req_size;
        lat_unmapped <= !mapped;
      end
    end
  end

  assign rd_src = cap_now ? mem_rdata : hold;
  assign rd_rot = {rd_src, rd_src} >> {lat_lane, 3'b000};

  // Format load data: lane select or ARM word rotation
  always_comb begin
    resp_rdata = rd_rot[31:0];
    if (lat_unmapped) begin
      resp_rdata = hold;
    end else begin
      unique case (lat_size)
        SZ_BYTE: resp_rdata = {24'd0, rd_rot[7:0]};
        SZ_HALF: resp_rdata = lat_lane[1] ?
                              {16'd0, rd_src[31:16]} :
                              {16'd0, rd_src[15:0]};
        default: resp_rdata = rd_rot[31:0];
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder.
// Latency, wait states, lanes, open bus, reset abort.
module tb_mem_bus_responder;
  import cpu_types_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_write;
  logic [31:0]  req_addr;
  access_size_t req_size;
  logic [31:0]  req_wdata;
  logic [15:0]  waitcnt;
  logic         busy;
  logic         resp_valid;
  logic [31:0]  resp_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [3:0]   mem_be;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_responder #(
    .EWRAM_WAIT(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .waitcnt   (waitcnt),
    .busy      (busy),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic         wr,
                         input logic [31:0]  addr,
                         input access_size_t sz,
                         input logic [31:0]  wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = sz;
    req_wdata = wd;
    #1;
  endtask

  task automatic finish(input string tag,
                        input int exp_lat,
                        input logic chk_rd,
                        input logic [31:0] exp_rd);
    int lat;
    int nbusy;
    nbusy = 0;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat - 1));
    if (chk_rd) chk({tag, " rdata"}, resp_rdata, exp_rd);
  endtask

  initial begin
    int pulses;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = SZ_WORD;
    req_wdata = '0;
    waitcnt   = 16'h0014;
    mem_rdata = '0;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;

    mem_rdata = 32'hDEADBEEF;
    present(1'b0, 32'h0300_0004, SZ_WORD, '0);
    chk("iwram mem_en", 32'(mem_en), 32'd1);
    chk("iwram mem_addr", mem_addr, 32'h0300_0004);
    finish("iwram word", 1, 1'b1, 32'hDEADBEEF);

    mem_rdata = 32'h11223344;
    present(1'b0, 32'h0300_0001, SZ_WORD, '0);
    chk("rot mem_addr", mem_addr, 32'h0300_0000);
    finish("rot word", 1, 1'b1, 32'h44112233);

    present(1'b0, 32'h0300_0002, SZ_BYTE, '0);
    finish("byte lane2", 1, 1'b1, 32'h0000_0022);

    present(1'b0, 32'h0300_0002, SZ_HALF, '0);
    finish("half hi", 1, 1'b1, 32'h0000_1122);

    present(1'b0, 32'h0100_0000, SZ_WORD, '0);
    chk("unmapped mem_en", 32'(mem_en), 32'd0);
    finish("open bus", 1, 1'b1, 32'h11223344);

    present(1'b1, 32'h0300_0002, SZ_HALF, 32'h0000_ABCD);
    chk("st mem_en", 32'(mem_en), 32'd1);
    chk("st mem_we", 32'(mem_we), 32'd1);
    chk("st mem_be", 32'(mem_be), 32'hC);
    chk("st mem_wdata", mem_wdata, 32'hABCDABCD);
    finish("store half", 1, 1'b0, '0);

    present(1'b1, 32'h0300_0003, SZ_BYTE, 32'h0000_005A);
    chk("stb mem_be", 32'(mem_be), 32'h8);
    chk("stb mem_wdata", mem_wdata, 32'h5A5A5A5A);
    finish("store byte", 1, 1'b0, '0);

    mem_rdata = 32'hCAFEF00D;
    present(1'b0, 32'h0200_0000, SZ_WORD, '0);
    finish("ewram", 3, 1'b1, 32'hCAFEF00D);

    tick();
    present(1'b0, 32'h0800_0000, SZ_WORD, '0);
    finish("rom n", 4, 1'b1, 32'hCAFEF00D);
    present(1'b0, 32'h0800_0004, SZ_WORD, '0);
    finish("rom s", 2, 1'b1, 32'hCAFEF00D);
    tick();
    present(1'b0, 32'h0800_0008, SZ_WORD, '0);
    finish("rom gap n", 4, 1'b0, '0);

    present(1'b0, 32'h0801_FFFC, SZ_WORD, '0);
    finish("rom pre-bnd", 4, 1'b0, '0);
    present(1'b0, 32'h0802_0000, SZ_WORD, '0);
    finish("rom 128k bnd", 4, 1'b0, '0);

    waitcnt = 16'h000C;
    present(1'b0, 32'h0800_0000, SZ_WORD, '0);
    tick();
    req_valid = 1'b0;
    chk("abort busy1", 32'(busy), 32'd1);
    tick();
    tick();
    chk("abort busy3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort resp_valid", 32'(resp_valid), 32'd0);
    pulses = 0;
    repeat (12) begin
      if (resp_valid) pulses++;
      tick();
    end
    chk("abort no resp", 32'(pulses), 32'd0);
    present(1'b0, 32'h0800_0004, SZ_WORD, '0);
    finish("post-abort n", 9, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
